gen_reg_file: RTL

GEN_REG_FILE -- requirements
Module: gen_reg_file

---
 rtl/gen_reg_file_if.sv | 43 ++++
 rtl/gen_reg_file.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/gen_reg_file_if.sv
// Bus bundle for gen_reg_file: write port, two read ports and the clear
// sequencer handshake. The master side drives requests, the slave side
// (the register file) returns registered results and status.
interface gen_reg_file_if #(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 10
);
    logic              wr_en;
    logic [1:0]        wr_sel;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_err;

    logic [1:0]        rd_a_sel;
    logic [ADDR_W-1:0] rd_a_addr;
    logic [DATA_W-1:0] rd_a_data;
    logic              rd_a_err;

    logic [1:0]        rd_b_sel;
    logic [ADDR_W-1:0] rd_b_addr;
    logic [DATA_W-1:0] rd_b_data;
    logic              rd_b_err;

    logic              clr_req;
    logic              busy;
    logic              clr_done;

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data,
        output rd_a_sel, rd_a_addr, rd_b_sel, rd_b_addr,
        output clr_req,
        input  wr_err, rd_a_data, rd_a_err, rd_b_data, rd_b_err,
        input  busy, clr_done
    );

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data,
        input  rd_a_sel, rd_a_addr, rd_b_sel, rd_b_addr,
        input  clr_req,
        output wr_err, rd_a_data, rd_a_err, rd_b_data, rd_b_err,
        output busy, clr_done
    );
endinterface

// File: rtl/gen_reg_file.sv
// Register file with one half-word-capable write port, two independent
// registered read ports (write-first on address collision) and a
// sequencer that zeroes every register, one per cycle, on request.
module gen_reg_file #(
    parameter int DATA_W   = 20,
    parameter int NUM_REGS = 6,
    parameter int ADDR_W   = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    gen_reg_file_if.slave bus
);
    localparam int HALF  = DATA_W / 2;
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    // One extra bit so NUM_REGS == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]  LIMIT = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_REGS - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    logic [IDX_W-1:0]  ptr;
    logic              busy_q;
    logic              clr_done_q;

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_a_idx;
    logic [IDX_W-1:0]  rd_b_idx;
    logic              wr_in_range;
    logic              wr_ok;
    logic              rd_a_ok;
    logic              rd_b_ok;
    logic [DATA_W-1:0] wr_old;
    logic [DATA_W-1:0] wr_merged;
    logic [DATA_W-1:0] rd_a_word;
    logic [DATA_W-1:0] rd_b_word;

    logic [DATA_W-1:0] rd_a_data_q;
    logic [DATA_W-1:0] rd_b_data_q;
    logic              rd_a_err_q;
    logic              rd_b_err_q;
    logic              wr_err_q;

    function automatic logic [DATA_W-1:0] merge_word(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [1:0]        sel
    );
        case (sel)
            2'b00:   merge_word = new_w;
            2'b01:   merge_word = {new_w[HALF-1:0], old_w[HALF-1:0]};
            2'b10:   merge_word = {old_w[DATA_W-1:HALF], new_w[HALF-1:0]};
            default: merge_word = old_w;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] shape_word(
        input logic [DATA_W-1:0] w,
        input logic [1:0]        sel
    );
        case (sel)
            2'b00:   shape_word = w;
            2'b01:   shape_word = {{HALF{1'b0}}, w[DATA_W-1:HALF]};
            2'b10:   shape_word = {{HALF{1'b0}}, w[HALF-1:0]};
            default: shape_word = '0;
        endcase
    endfunction

    // Decode write acceptance and build the write-first view seen by each read port
    always_comb begin
        wr_idx      = bus.wr_addr[IDX_W-1:0];
        rd_a_idx    = bus.rd_a_addr[IDX_W-1:0];
        rd_b_idx    = bus.rd_b_addr[IDX_W-1:0];
        wr_in_range = ({1'b0, bus.wr_addr} < LIMIT);
        wr_ok       = bus.wr_en && wr_in_range && (bus.wr_sel != 2'b11)
                      && (state == IDLE) && !bus.clr_req;
        wr_old      = wr_in_range ? regs[wr_idx] : '0;
        wr_merged   = merge_word(wr_old, bus.wr_data, bus.wr_sel);

        rd_a_ok   = ({1'b0, bus.rd_a_addr} < LIMIT) && (bus.rd_a_sel != 2'b11);
        rd_b_ok   = ({1'b0, bus.rd_b_addr} < LIMIT) && (bus.rd_b_sel != 2'b11);
        rd_a_word = '0;
        rd_b_word = '0;
        if (rd_a_ok) begin
            rd_a_word = (wr_ok && (bus.wr_addr == bus.rd_a_addr)) ? wr_merged : regs[rd_a_idx];
        end
        if (rd_b_ok) begin
            rd_b_word = (wr_ok && (bus.wr_addr == bus.rd_b_addr)) ? wr_merged : regs[rd_b_idx];
        end
    end

    // Clear sequencer: walk the pointer over every register, then pulse done
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            busy_q     <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            clr_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.clr_req) begin
                        state  <= CLEAR;
                        ptr    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (ptr == LAST) begin
                        state      <= IDLE;
                        busy_q     <= 1'b0;
                        clr_done_q <= 1'b1;
                    end else begin
                        ptr <= ptr + IDX_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage update: clearing owns the array while busy, otherwise accepted writes land
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (state == CLEAR) begin
            regs[ptr] <= '0;
        end else if (wr_ok) begin
            regs[wr_idx] <= wr_merged;
        end
    end

    // Register read results and error flags for both ports
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_a_data_q <= '0;
            rd_b_data_q <= '0;
            rd_a_err_q  <= 1'b0;
            rd_b_err_q  <= 1'b0;
            wr_err_q    <= 1'b0;
        end else begin
            rd_a_data_q <= rd_a_ok ? shape_word(rd_a_word, bus.rd_a_sel) : '0;
            rd_b_data_q <= rd_b_ok ? shape_word(rd_b_word, bus.rd_b_sel) : '0;
            rd_a_err_q  <= !rd_a_ok;
            rd_b_err_q  <= !rd_b_ok;
            wr_err_q    <= bus.wr_en && !wr_ok;
        end
    end

    assign bus.rd_a_data = rd_a_data_q;
    assign bus.rd_b_data = rd_b_data_q;
    assign bus.rd_a_err  = rd_a_err_q;
    assign bus.rd_b_err  = rd_b_err_q;
    assign bus.wr_err    = wr_err_q;
    assign bus.busy      = busy_q;
    assign bus.clr_done  = clr_done_q;
endmodule
